design04_driver: RTL and testbench

DESIGN04_DRIVER -- requirements
Module: design04_driver

---
 rtl/design04_pkg.sv | 23 ++
 rtl/design04_if.sv | 28 ++
 rtl/design04_lfsr8.sv | 24 ++
 rtl/design04_driver.sv | 163 ++++++++++++++++
 tb/tb_design04_driver.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/design04_pkg.sv
// Shared types and constants for the design04 transaction driver.
package design04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    CHECK,
    NEXT,
    DONE
  } state_t;

  localparam int unsigned WIDTH_DEFAULT = 8;

  // Right-shift Galois mask for x^8 + x^6 + x^5 + x^4 + 1.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == '0) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/design04_if.sv
// Method-style handshake between the driver (master) and the adder DUT (slave).
interface design04_if
  import design04_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) ();

  logic [WIDTH-1:0] start_a;
  logic [WIDTH-1:0] start_b;
  logic             EN_start;
  logic             RDY_start;
  logic [WIDTH-1:0] resresult_;
  logic             RDY_result;
  logic             EN_check;
  logic [WIDTH-1:0] chresult_;
  logic             RDY_check;

  modport master (
    output start_a, start_b, EN_start, EN_check,
    input  RDY_start, resresult_, RDY_result, chresult_, RDY_check
  );

  modport slave (
    input  start_a, start_b, EN_start, EN_check,
    output RDY_start, resresult_, RDY_result, chresult_, RDY_check
  );

endinterface

// File: rtl/design04_lfsr8.sv
// 8-bit Galois LFSR operand generator with synchronous load and step.
module lfsr8
  import design04_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [7:0] value
);

  localparam logic [7:0] INIT = seed_fix(SEED);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      value <= INIT;
    end else if (step) begin
      value <= value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
    end
  end

endmodule

// File: rtl/design04_driver.sv
// Self-checking stimulus driver: issues LFSR operand pairs to an adder DUT,
// verifies both result and check methods, and tallies pass/fail per run.
module design04_driver
  import design04_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEFAULT,
  parameter int unsigned NUM_TXN = 16,
  parameter logic [7:0]  SEED    = 8'hA5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       go,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_count,
  output logic [7:0] fail_count,
  output logic       timeout,
  design04_if.master dut
);

  state_t state, state_n;

  logic [7:0]       lfsr;
  logic [7:0]       txn_idx;
  logic [7:0]       wait_cnt;
  logic [WIDTH-1:0] a_r, b_r, exp_r, res_r;
  logic [WIDTH-1:0] op_a, op_b;
  logic             res_ok;
  logic             waiting, wait_last, last_txn;
  logic             en_start, en_check;
  logic             lfsr_load, lfsr_step;
  logic             clr_run, latch_op, cap_res, pass_inc, fail_inc, set_to;

  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk   (CLK),
    .rst   (RST),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (lfsr)
  );

  assign op_a      = WIDTH'(lfsr);
  assign op_b      = WIDTH'({lfsr[3:0], lfsr[7:4]});
  assign waiting   = (state == ISSUE) || (state == WAIT_RES) || (state == CHECK);
  assign wait_last = (32'(wait_cnt) + 32'd1 >= TIMEOUT);
  assign last_txn  = (txn_idx == 8'(NUM_TXN - 1));

  // Operands track the LFSR live while issuing, then hold the latched pair.
  assign dut.start_a  = (state == ISSUE) ? op_a : a_r;
  assign dut.start_b  = (state == ISSUE) ? op_b : b_r;
  assign dut.EN_start = en_start;
  assign dut.EN_check = en_check;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    en_start  = 1'b0;
    en_check  = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    clr_run   = 1'b0;
    latch_op  = 1'b0;
    cap_res   = 1'b0;
    pass_inc  = 1'b0;
    fail_inc  = 1'b0;
    set_to    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (go) begin
          clr_run   = 1'b1;
          lfsr_load = 1'b1;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        if (dut.RDY_start) begin
          en_start = 1'b1;
          latch_op = 1'b1;
          state_n  = WAIT_RES;
        end else if (wait_last) begin
          set_to   = 1'b1;
          fail_inc = 1'b1;
          state_n  = NEXT;
        end
      end
      WAIT_RES: begin
        if (dut.RDY_result) begin
          cap_res = 1'b1;
          state_n = CHECK;
        end else if (wait_last) begin
          set_to   = 1'b1;
          fail_inc = 1'b1;
          state_n  = NEXT;
        end
      end
      CHECK: begin
        if (dut.RDY_check) begin
          en_check = 1'b1;
          if (res_ok && (dut.chresult_ == res_r)) pass_inc = 1'b1;
          else                                    fail_inc = 1'b1;
          state_n = NEXT;
        end else if (wait_last) begin
          set_to   = 1'b1;
          fail_inc = 1'b1;
          state_n  = NEXT;
        end
      end
      NEXT: begin
        lfsr_step = 1'b1;
        state_n   = last_txn ? DONE : ISSUE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || !waiting || (state_n != state)) wait_cnt <= '0;
    else                                       wait_cnt <= wait_cnt + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pass_count <= '0;
      fail_count <= '0;
      timeout    <= 1'b0;
      txn_idx    <= '0;
      a_r        <= '0;
      b_r        <= '0;
      exp_r      <= '0;
      res_r      <= '0;
      res_ok     <= 1'b0;
    end else begin
      if (clr_run) begin
        pass_count <= '0;
        fail_count <= '0;
        timeout    <= 1'b0;
        txn_idx    <= '0;
      end
      if (latch_op) begin
        a_r   <= op_a;
        b_r   <= op_b;
        exp_r <= op_a + op_b;
      end
      if (cap_res) begin
        res_r  <= dut.resresult_;
        res_ok <= (dut.resresult_ == exp_r);
      end
      if (pass_inc) pass_count <= pass_count + 8'd1;
      if (fail_inc && (fail_count != '1)) fail_count <= fail_count + 8'd1;
      if (set_to) timeout <= 1'b1;
      if (lfsr_step) txn_idx <= txn_idx + 8'd1;
    end
  end

endmodule

// File: tb/tb_design04_driver.sv
// Bench for design04_driver: responsive adder models, scenario table, and
// directed sequences for timeout timing, mid-run reset and zero seed.
module tb_design04_driver;
  import design04_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic go1 = 1'b0, go2 = 1'b0;
  logic busy1, done1, to1, busy2, done2, to2;
  logic [7:0] pass1, fail1, pass2, fail2;

  design04_if #(.WIDTH(8)) bus1 ();
  design04_if #(.WIDTH(8)) bus2 ();

  design04_driver #(.WIDTH(8), .NUM_TXN(16), .SEED(8'hA5), .TIMEOUT(10)) u1 (
    .CLK(clk), .RST(rst), .go(go1), .busy(busy1), .done(done1),
    .pass_count(pass1), .fail_count(fail1), .timeout(to1), .dut(bus1.master)
  );

  design04_driver #(.WIDTH(8), .NUM_TXN(1), .SEED(8'h00)) u2 (
    .CLK(clk), .RST(rst), .go(go2), .busy(busy2), .done(done2),
    .pass_count(pass2), .fail_count(fail2), .timeout(to2), .dut(bus2.master)
  );

  // Adder model for u1 with knobs for ready toggling, stalls and corruption.
  logic       mode_tog = 1'b0, blk0 = 1'b0, cor3 = 1'b0, tog = 1'b0, have1 = 1'b0;
  logic [7:0] held1 = '0, scnt1 = '0, ccnt1 = '0, ovl1 = '0;
  logic [7:0] base_s = '0, base_c = '0;
  logic [7:0] alog [256];
  logic [7:0] blog [256];
  logic [7:0] rel;

  assign rel = scnt1 - base_s;

  always @(posedge clk) begin
    tog <= ~tog;
    if (bus1.EN_start) begin
      held1       <= bus1.start_a + bus1.start_b;
      have1       <= 1'b1;
      alog[scnt1] <= bus1.start_a;
      blog[scnt1] <= bus1.start_b;
      scnt1       <= scnt1 + 8'd1;
    end
    if (bus1.EN_check) ccnt1 <= ccnt1 + 8'd1;
    if (bus1.EN_start && bus1.EN_check) ovl1 <= ovl1 + 8'd1;
  end

  assign bus1.RDY_start  = mode_tog ? tog : 1'b1;
  assign bus1.RDY_result = have1 && !(blk0 && rel == 8'd1);
  assign bus1.resresult_ = held1 + ((cor3 && rel == 8'd4) ? 8'd1 : 8'd0);
  assign bus1.chresult_  = held1;
  assign bus1.RDY_check  = 1'b1;

  logic [7:0] held2 = '0, a2 = '0, b2 = '0;
  logic       have2 = 1'b0;
  always @(posedge clk) begin
    if (bus2.EN_start) begin
      held2 <= bus2.start_a + bus2.start_b;
      have2 <= 1'b1;
      a2    <= bus2.start_a;
      b2    <= bus2.start_b;
    end
  end
  assign bus2.RDY_start  = 1'b1;
  assign bus2.RDY_result = have2;
  assign bus2.resresult_ = held2;
  assign bus2.chresult_  = held2;
  assign bus2.RDY_check  = 1'b1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic start1();
    @(negedge clk);
    base_s = scnt1;
    base_c = ccnt1;
    go1 = 1'b1;
    @(negedge clk);
    go1 = 1'b0;
  endtask

  task automatic wait_done1(input string nm);
    int unsigned k;
    k = 0;
    while (!done1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done"}, 32'(done1), 32'd1);
  endtask

  typedef struct {
    string      name;
    logic       tg;
    logic       bk;
    logic       cr;
    logic [7:0] pass;
    logic [7:0] fail;
    logic       to;
    logic [7:0] ens;
    logic [7:0] enc;
  } vec_t;

  vec_t vt [4];

  initial begin
    int unsigned k;
    vt[0] = '{"ready",   1'b0, 1'b0, 1'b0, 8'd16, 8'd0, 1'b0, 8'd16, 8'd16};
    vt[1] = '{"corrupt", 1'b0, 1'b0, 1'b1, 8'd15, 8'd1, 1'b0, 8'd16, 8'd16};
    vt[2] = '{"stall",   1'b0, 1'b1, 1'b0, 8'd15, 8'd1, 1'b1, 8'd16, 8'd15};
    vt[3] = '{"toggle",  1'b1, 1'b0, 1'b0, 8'd16, 8'd0, 1'b0, 8'd16, 8'd16};

    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy1), 32'd0);
    chk("rst_done",  32'(done1), 32'd0);
    chk("rst_pass",  32'(pass1), 32'd0);
    chk("rst_fail",  32'(fail1), 32'd0);
    chk("rst_to",    32'(to1), 32'd0);
    chk("rst_ens",   32'(bus1.EN_start), 32'd0);
    chk("rst_enc",   32'(bus1.EN_check), 32'd0);
    chk("rst_a",     32'(bus1.start_a), 32'd0);
    chk("rst_b",     32'(bus1.start_b), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mode_tog = vt[i].tg;
      blk0     = vt[i].bk;
      cor3     = vt[i].cr;
      start1();
      wait_done1(vt[i].name);
      chk({vt[i].name, "_pass"}, 32'(pass1), 32'(vt[i].pass));
      chk({vt[i].name, "_fail"}, 32'(fail1), 32'(vt[i].fail));
      chk({vt[i].name, "_to"},   32'(to1),   32'(vt[i].to));
      chk({vt[i].name, "_ens"},  32'(8'(scnt1 - base_s)), 32'(vt[i].ens));
      chk({vt[i].name, "_enc"},  32'(8'(ccnt1 - base_c)), 32'(vt[i].enc));
      chk({vt[i].name, "_busy"}, 32'(busy1), 32'd0);
      chk({vt[i].name, "_a0"},   32'(alog[base_s]), 32'h0A5);
      chk({vt[i].name, "_b0"},   32'(blog[base_s]), 32'h05A);
      chk({vt[i].name, "_a1"},   32'(alog[8'(base_s + 8'd1)]), 32'h0EA);
      chk({vt[i].name, "_b1"},   32'(blog[8'(base_s + 8'd1)]), 32'h0AE);
    end
    mode_tog = 1'b0;
    blk0     = 1'b0;
    cor3     = 1'b0;

    // Stalled result on txn 0: timeout lands exactly after ten WAIT_RES cycles.
    blk0 = 1'b1;
    start1();
    k = 0;
    while (!bus1.EN_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("to_issue", 32'(bus1.EN_start), 32'd1);
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 chk("to_early", 32'(to1), 32'd0);
    @(posedge clk);
    #1 chk("to_set", 32'(to1), 32'd1);
    chk("to_no_check", 32'(8'(ccnt1 - base_c)), 32'd0);
    chk("to_busy", 32'(busy1), 32'd1);
    wait_done1("to_run");
    chk("to_fail", 32'(fail1), 32'd1);
    chk("to_pass", 32'(pass1), 32'd15);
    blk0 = 1'b0;

    // Reset while in CHECK of transaction 5, then a clean rerun.
    start1();
    k = 0;
    while (!(bus1.EN_check && rel == 8'd6) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("mid_found", 32'(bus1.EN_check && rel == 8'd6), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy1), 32'd0);
    chk("mid_done", 32'(done1), 32'd0);
    chk("mid_pass", 32'(pass1), 32'd0);
    chk("mid_fail", 32'(fail1), 32'd0);
    chk("mid_to",   32'(to1), 32'd0);
    chk("mid_ens",  32'(bus1.EN_start), 32'd0);
    chk("mid_enc",  32'(bus1.EN_check), 32'd0);
    chk("mid_a",    32'(bus1.start_a), 32'd0);
    chk("mid_b",    32'(bus1.start_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start1();
    wait_done1("rerun");
    chk("rerun_pass", 32'(pass1), 32'd16);
    chk("rerun_fail", 32'(fail1), 32'd0);
    chk("rerun_a0",   32'(alog[base_s]), 32'h0A5);
    chk("overlap",    32'(ovl1), 32'd0);

    // Zero seed, single transaction.
    @(negedge clk);
    go2 = 1'b1;
    @(negedge clk);
    go2 = 1'b0;
    k = 0;
    while (!done2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("s0_done", 32'(done2), 32'd1);
    chk("s0_a",    32'(a2), 32'h001);
    chk("s0_b",    32'(b2), 32'h010);
    chk("s0_pass", 32'(pass2), 32'd1);
    chk("s0_fail", 32'(fail2), 32'd0);
    chk("s0_to",   32'(to2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
